fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one fetch per fetch_enable pulse, fixed-latency instruction memory.
// Optional protocol checker enabled by defining FETCH_PROTO_CHECK_EN.
module fetch_stage #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter logic [31:0] INIT_PC     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        fetch_enable,
   output logic        fetch_done,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        mem_en,
   output logic [14:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        proto_err
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_nxt;
   logic [3:0]  lat_cnt;
   logic [31:0] fetch_addr;
   logic [31:0] next_addr;
   logic        first_fetch;
   logic        accept;
   logic        capture;

   // The fetch_done cycle still belongs to WAIT, so a pulse landing there is ignored.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      next_addr = first_fetch  ? INIT_PC :
                  branch_taken ? branch_target : pc + 32'd4;
      case (state)
         IDLE: begin
            if (fetch_enable) begin
               accept    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (fetch_done)
               state_nxt = IDLE;
            else if (lat_cnt == 4'(MEM_LATENCY))
               capture = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         fetch_done  <= 1'b0;
         mem_en      <= 1'b0;
         mem_addr    <= '0;
         pc          <= INIT_PC;
         instr       <= '0;
         lat_cnt     <= '0;
         fetch_addr  <= '0;
         first_fetch <= 1'b1;
      end else begin
         state      <= state_nxt;
         mem_en     <= accept;
         fetch_done <= capture;
         if (accept) begin
            fetch_addr  <= next_addr;
            mem_addr    <= next_addr[16:2];
            lat_cnt     <= '0;
            first_fetch <= 1'b0;
         end else if (capture) begin
            pc      <= fetch_addr;
            instr   <= mem_rdata;
            lat_cnt <= '0;
         end else if (state == WAIT && !fetch_done) begin
            lat_cnt <= lat_cnt + 4'd1;
         end
      end
   end

`ifdef FETCH_PROTO_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rstn)
         proto_err <= 1'b0;
      else if (state == WAIT && fetch_enable)
         proto_err <= 1'b1;
   end
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of fetch vectors plus hand sequences for
// idle branch noise, a double fetch_enable, reset during WAIT and PC wrap.
module tb_fetch_stage;

   localparam int unsigned L = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        fetch_enable = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        fetch_done;
   logic [31:0] pc, instr, mem_rdata;
   logic        mem_en;
   logic [14:0] mem_addr;
   logic        proto_err;

   logic [15:0] sh = '0;
   logic [31:0] mem_word = '0;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.MEM_LATENCY(L), .INIT_PC(32'h0000_0000)) dut (
      .clk(clk), .rstn(rstn), .fetch_enable(fetch_enable), .fetch_done(fetch_done),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .instr(instr), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // Memory model: data is valid only exactly L cycles after the mem_en cycle.
   always @(posedge clk) sh <= {sh[14:0], mem_en};
   assign mem_rdata = sh[L-1] ? mem_word : 32'h0BAD_0BAD;

   typedef struct {
      logic        br;
      logic [31:0] tgt;
      logic [31:0] word;
      logic [14:0] addr;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_fetch(input string tag, input logic br, input logic [31:0] tgt,
                           input logic [31:0] word, input logic [14:0] exp_addr,
                           input logic [31:0] exp_pc, input int extra_en);
      int          n_mem_en = 0;
      int          n_done = 0;
      int          lat = -1;
      logic [14:0] got_addr = '0;
      logic        stable = 1'b1;
      logic [31:0] pc0, instr0;
      logic [31:0] pc_d = '0;
      logic [31:0] instr_d = '0;
      mem_word = word;
      @(negedge clk);
      pc0 = pc;
      instr0 = instr;
      fetch_enable = 1'b1;
      branch_taken = br;
      branch_target = tgt;
      for (int k = 1; k <= int'(L) + 8; k++) begin
         @(negedge clk);
         if (mem_en) begin
            n_mem_en++;
            got_addr = mem_addr;
         end
         if (fetch_done) begin
            n_done++;
            if (lat < 0) begin
               lat = k;
               pc_d = pc;
               instr_d = instr;
            end
         end else if (lat < 0 && (pc !== pc0 || instr !== instr0)) begin
            stable = 1'b0;
         end
         if (n_mem_en > 0 && lat < 0 && mem_addr !== got_addr) stable = 1'b0;
         fetch_enable = (k == extra_en);
         branch_taken = 1'b1;
         branch_target = 32'h0000_0ABC;
      end
      fetch_enable = 1'b0;
      branch_taken = 1'b0;
      chk({tag, " mem_en_count"}, 32'(n_mem_en), 32'd1);
      chk({tag, " mem_addr"}, {17'd0, got_addr}, {17'd0, exp_addr});
      chk({tag, " latency"}, 32'(lat), 32'(L + 2));
      chk({tag, " done_count"}, 32'(n_done), 32'd1);
      chk({tag, " pc"}, pc_d, exp_pc);
      chk({tag, " instr"}, instr_d, word);
      chk({tag, " stable"}, {31'd0, stable}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done, n_en;

      vecs[0] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 15'h0000, 32'h0000_0000};
      vecs[1] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 15'h0001, 32'h0000_0004};
      vecs[2] = '{1'b1, 32'h0000_0100, 32'hA5A5_0001, 15'h0040, 32'h0000_0100};
      vecs[3] = '{1'b0, 32'h0000_0000, 32'hA5A5_0002, 15'h0041, 32'h0000_0104};
      vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_0003, 15'h7FFF, 32'hFFFF_FFFC};
      vecs[5] = '{1'b0, 32'h0000_0000, 32'hA5A5_0004, 15'h0000, 32'h0000_0000};
      vecs[6] = '{1'b1, 32'h0001_2348, 32'hA5A5_0005, 15'h48D2, 32'h0001_2348};
      vecs[7] = '{1'b1, 32'h0003_0000, 32'hA5A5_0006, 15'h4000, 32'h0003_0000};

      repeat (3) @(negedge clk);
      chk("rst pc", pc, 32'h0);
      chk("rst instr", instr, 32'h0);
      chk("rst mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst fetch_done", {31'd0, fetch_done}, 32'd0);
      chk("rst mem_addr", {17'd0, mem_addr}, 32'd0);
      chk("rst proto_err", {31'd0, proto_err}, 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < 8; i++)
         do_fetch($sformatf("v%0d", i), vecs[i].br, vecs[i].tgt, vecs[i].word,
                  vecs[i].addr, vecs[i].pc, 0);

      @(negedge clk);
      branch_taken = 1'b1;
      branch_target = 32'h0000_0500;
      @(negedge clk);
      branch_taken = 1'b0;
      do_fetch("idle_br", 1'b0, 32'h0, 32'h1111_2222, 15'h4001, 32'h0003_0004, 0);
      chk("proto_err clean", {31'd0, proto_err}, 32'd0);

      do_fetch("dbl_en", 1'b0, 32'h0, 32'h3333_4444, 15'h4002, 32'h0003_0008, 1);
`ifdef FETCH_PROTO_CHECK_EN
      chk("proto_err dbl", {31'd0, proto_err}, 32'd1);
`else
      chk("proto_err dbl", {31'd0, proto_err}, 32'd0);
`endif

      mem_word = 32'h5555_6666;
      @(negedge clk);
      fetch_enable = 1'b1;
      @(negedge clk);
      fetch_enable = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      n_done = 0;
      n_en = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (fetch_done) n_done++;
         if (mem_en) n_en++;
      end
      chk("rst_wait done_count", 32'(n_done), 32'd0);
      chk("rst_wait mem_en_count", 32'(n_en), 32'd0);
      chk("rst_wait pc", pc, 32'h0);
      chk("rst_wait instr", instr, 32'h0);
      chk("rst_wait proto_err", {31'd0, proto_err}, 32'd0);

      do_fetch("post_rst", 1'b1, 32'h0000_0200, 32'h7777_8888, 15'h0000, 32'h0000_0000, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
